// File: rtl/iter_multdiv.sv
// iter_multdiv: iterative signed Booth multiplier / non-restoring divider with one-pulse ready handshake.
// Define MULTDIV_RADIX4_EN to switch the multiplier to radix-4 Booth (16 steps); divide is unaffected.
module iter_multdiv (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;
  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, mc_q, mc_d, res_q, res_d;
  logic [33:0] rem_q, rem_d;
  logic        qm_q, qm_d, neg_q, neg_d, dz_q, dz_d, div_q, div_d;
  logic        exc_q, exc_d, rdy_q, rdy_d, busy_q, busy_d;
  logic [31:0] b_hi, b_lo, qres;
  logic        b_qm, mexc;
  logic [33:0] rs, rn;
`ifdef MULTDIV_RADIX4_EN
  localparam logic [5:0] MLAST = 6'd15;
  logic [2:0]  rec;
  logic [33:0] m34, pp, bsum;
  assign rec  = {lo_q[1:0], qm_q};
  assign m34  = {{2{mc_q[31]}}, mc_q};
  assign pp   = (rec == 3'b001 || rec == 3'b010) ? m34 :
                rec == 3'b011 ? m34 << 1 :
                rec == 3'b100 ? -(m34 << 1) :
                (rec == 3'b101 || rec == 3'b110) ? -m34 : '0;
  assign bsum = {{2{hi_q[31]}}, hi_q} + pp;
  assign b_hi = bsum[33:2];
  assign b_lo = {bsum[1:0], lo_q[31:2]};
  assign b_qm = lo_q[1];
`else
  localparam logic [5:0] MLAST = 6'd31;
  logic [32:0] m33, pp, bsum;
  assign m33  = {mc_q[31], mc_q};
  assign pp   = lo_q[0] == qm_q ? '0 : lo_q[0] ? -m33 : m33;
  assign bsum = {hi_q[31], hi_q} + pp;
  assign b_hi = bsum[32:1];
  assign b_lo = {bsum[0], lo_q[31:1]};
  assign b_qm = lo_q[0];
`endif
  // remainder is kept one bit wider than the shifted value so its sign survives 2r+1 near 2^32
  assign rs   = {rem_q[32:0], lo_q[31]};
  assign rn   = rem_q[33] ? rs + {2'b0, mc_q} : rs - {2'b0, mc_q};
  assign qres = neg_q ? -lo_q : lo_q;
  assign mexc = !(&{hi_q, lo_q[31]} || ~|{hi_q, lo_q[31]});
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    qm_d    = qm_q;
    mc_d    = mc_q;
    rem_d   = rem_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    div_d   = div_q;
    res_d   = res_q;
    exc_d   = exc_q;
    rdy_d   = 1'b0;
    if (ctrl_MULT || ctrl_DIV) begin
      state_d = ctrl_MULT ? MUL : DIV;
      div_d   = !ctrl_MULT;
      cnt_d   = '0;
      hi_d    = '0;
      qm_d    = 1'b0;
      rem_d   = '0;
      mc_d    = ctrl_MULT ? data_operandA : (data_operandB[31] ? -data_operandB : data_operandB);
      lo_d    = ctrl_MULT ? data_operandB : (data_operandA[31] ? -data_operandA : data_operandA);
      neg_d   = data_operandA[31] ^ data_operandB[31];
      dz_d    = data_operandB == '0;
    end else begin
      case (state_q)
        MUL: begin
          hi_d    = b_hi;
          lo_d    = b_lo;
          qm_d    = b_qm;
          cnt_d   = cnt_q + 6'd1;
          state_d = cnt_q == MLAST ? FIN : MUL;
        end
        DIV: begin
          rem_d   = rn;
          lo_d    = {lo_q[30:0], ~rn[33]};
          cnt_d   = cnt_q + 6'd1;
          state_d = cnt_q == 6'd31 ? FIN : DIV;
        end
        FIN: begin
          state_d = IDLE;
          rdy_d   = 1'b1;
          res_d   = div_q ? (dz_q ? '0 : qres) : lo_q;
          exc_d   = div_q ? (dz_q | (lo_q[31] & ~neg_q)) : mexc;
        end
        default: ;
      endcase
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      qm_q    <= 1'b0;
      mc_q    <= '0;
      rem_q   <= '0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      div_q   <= 1'b0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      qm_q    <= qm_d;
      mc_q    <= mc_d;
      rem_q   <= rem_d;
      neg_q   <= neg_d;
      dz_q    <= dz_d;
      div_q   <= div_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end
  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;
endmodule

// File: tb/tb_iter_multdiv.sv
// tb_iter_multdiv: scoreboard bench for iter_multdiv; honours MULTDIV_RADIX4_EN for multiply latency.
module tb_iter_multdiv;
`ifdef MULTDIV_RADIX4_EN
  localparam int MS = 16;
`else
  localparam int MS = 32;
`endif
  typedef struct {logic [31:0] res; logic exc; int due;} exp_t;
  logic        clock = 0, reset = 1, ctrl_MULT = 0, ctrl_DIV = 0;
  logic [31:0] data_operandA = 0, data_operandB = 0;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;
  exp_t        sb[$];
  exp_t        mon_e;
  int          cyc = 0, tests = 0, fails = 0;
  logic        prev_rdy = 0;

  iter_multdiv dut (
    .clock(clock), .reset(reset), .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .data_result(data_result),
    .data_exception(data_exception), .data_resultRDY(data_resultRDY), .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input bit m, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] p;
    e.due = 0;
    if (m) begin
      p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      e.res = p[31:0];
      e.exc = !(p[63:31] == '0 || p[63:31] == '1);
    end else if (b == 0) begin
      e.res = 0;
      e.exc = 1;
    end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      e.res = 32'h80000000;
      e.exc = 1;
    end else begin
      e.res = 32'($signed(a) / $signed(b));
      e.exc = 0;
    end
    return e;
  endfunction

  task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b, input bit push);
    exp_t e;
    @(negedge clock);
    ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT = 0; ctrl_DIV = 0; data_operandA = $urandom; data_operandB = $urandom;
    if (push) begin
      e = model(m, a, b);
      e.due = cyc + (m ? MS : 32) + 1;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      #1;
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      check("timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  always @(negedge clock) begin
    if (data_resultRDY && prev_rdy) check("rdy_width", 2, 1);
    prev_rdy <= data_resultRDY;
    if (data_resultRDY) begin
      if (sb.size() == 0) check("spurious_rdy", 1, 0);
      else begin
        mon_e = sb.pop_front();
        check("result", data_result, mon_e.res);
        check("exception", data_exception, mon_e.exc);
        check("latency", cyc, mon_e.due);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_result", data_result, 0);
    check("rst_exc", data_exception, 0);
    check("rst_rdy", data_resultRDY, 0);
    check("rst_busy", busy, 0);
    reset = 0;
    start_op(1, 0, 7, -32'sd3, 1);
    @(negedge clock);
    check("busy_mul", busy, 1);
    wait_idle();
    @(negedge clock);
    check("rdy_one_cycle", data_resultRDY, 0);
    check("busy_done", busy, 0);
    start_op(1, 0, 32'h00010000, 32'h00010000, 1); wait_idle();
    start_op(1, 0, 32'h80000000, 32'h80000000, 1); wait_idle();
    start_op(1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1); wait_idle();
    start_op(1, 0, 32'h80000000, 32'h00000001, 1); wait_idle();
    start_op(0, 1, -32'sd100, 7, 1); wait_idle();
    start_op(0, 1, 5, 0, 1); wait_idle();
    start_op(0, 1, 32'h80000000, 32'hFFFFFFFF, 1); wait_idle();
    start_op(0, 1, 32'h80000000, 32'h00000001, 1); wait_idle();
    start_op(0, 1, 32'h7FFFFFFF, 32'h80000000, 1); wait_idle();
    // multiply aborted by a divide ten edges later: only the divide reports
    start_op(1, 0, 6, 6, 0);
    repeat (9) @(posedge clock);
    start_op(0, 1, 100, 10, 1);
    wait_idle();
    repeat (40) @(negedge clock);
    // reset at edge 20 of a divide abandons it
    start_op(0, 1, 1000, 3, 0);
    repeat (19) @(negedge clock);
    reset = 1;
    @(posedge clock);
    #1;
    reset = 0;
    @(negedge clock);
    check("busy_after_rst", busy, 0);
    repeat (40) @(negedge clock);
    start_op(1, 0, 3, 4, 1); wait_idle();
    // reset wins over a simultaneous start
    @(negedge clock);
    reset = 1; ctrl_MULT = 1; data_operandA = 5; data_operandB = 5;
    @(posedge clock);
    #1;
    reset = 0; ctrl_MULT = 0;
    @(negedge clock);
    check("busy_rst_start", busy, 0);
    repeat (40) @(negedge clock);
    start_op(1, 1, 9, 3, 1); wait_idle();
    for (int i = 0; i < 8; i++) begin
      start_op(1, 0, $urandom, $urandom, 1); wait_idle();
      start_op(0, 1, $urandom, $urandom_range(1, 5000) * (i[0] ? -1 : 1), 1); wait_idle();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/iter_multdiv.md
ITER_MULTDIV -- requirements
Module: iter_multdiv

Interface
REQ-001 clock  input  1  master clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 data_operandA  input  32  signed multiplicand / dividend; sampled only on a start edge.
REQ-004 data_operandB  input  32  signed multiplier / divisor; sampled only on a start edge.
REQ-005 ctrl_MULT  input  1  one-cycle start pulse for multiply.
REQ-006 ctrl_DIV  input  1  one-cycle start pulse for divide.
REQ-007 data_result  output  32  registered result; low 32 bits of product or truncated quotient.
REQ-008 data_exception  output  1  registered; valid in the same cycle as data_resultRDY.
REQ-009 data_resultRDY  output  1  registered; high for exactly one cycle per completed operation.
REQ-010 busy  output  1  high while an operation is in progress (states MUL, DIV, FIN).

Function
REQ-011 The block SHALL be the responder to the execute-stage multdiv handshake: the pipeline pulses ctrl_MULT/ctrl_DIV once and stalls until data_resultRDY.
REQ-012 FSM states SHALL be IDLE, MUL, DIV and FIN. IDLE->MUL on ctrl_MULT. IDLE->DIV on ctrl_DIV. MUL/DIV->FIN when the iteration counter reaches its terminal count. FIN->IDLE unconditionally.
REQ-013 A start edge SHALL latch both operands and clear the 6-bit iteration counter.
REQ-014 ctrl_MULT and ctrl_DIV high on the same edge SHALL be treated as multiply only.
REQ-015 A start pulse in any state other than IDLE SHALL abort the current operation and restart with the new operands; no data_resultRDY SHALL be issued for the aborted operation.
REQ-016 Multiply SHALL use signed Booth recoding over a 65-bit product register {hi, lo, q-1}, one recoding step per cycle in radix-2 mode (32 steps).
REQ-017 Divide SHALL use non-restoring division on operand magnitudes, one quotient bit per cycle (32 steps); the quotient sign SHALL be A[31]^B[31]; the quotient SHALL be truncated toward zero; the remainder SHALL be discarded.
REQ-018 Latency: with start at edge N and steps S, data_resultRDY SHALL be high in the cycle after edge N+S+1. S=32 for divide and radix-2 multiply, giving data_resultRDY in the cycle after edge N+33.
REQ-019 data_result and data_exception SHALL update on the FIN->IDLE edge and hold until the next completion or reset.
REQ-020 Multiply exception SHALL be 1 when product bits [63:31] are not all equal (signed 32-bit overflow); data_result SHALL still carry product[31:0].
REQ-021 Divide by zero SHALL give data_result=0 and data_exception=1, with normal latency.
REQ-022 0x80000000 / -1 SHALL give data_result=0x80000000 and data_exception=1.
REQ-023 Operand changes after the start edge SHALL NOT affect the result.

Reset
REQ-024 When reset is high at an edge, the block SHALL enter IDLE, clear the counter and all datapath registers, and set data_result=0, data_exception=0, data_resultRDY=0, busy=0.
REQ-025 Reset mid-operation SHALL abandon the operation without issuing data_resultRDY.
REQ-026 Reset SHALL take priority over a simultaneous start pulse.

Configuration
REQ-027 Macro MULTDIV_RADIX4_EN defined: multiply SHALL use radix-4 Booth recoding, taking 2 bits per cycle over 16 steps, so multiply data_resultRDY falls in the cycle after edge N+17; divide SHALL be unchanged.
REQ-028 Macro MULTDIV_RADIX4_EN undefined: multiply SHALL be radix-2 as in REQ-016 and REQ-018. Results and exceptions SHALL be bit-identical in both builds.

Verification
REQ-029 Multiply 7 x -3: start at edge 0 -> data_result=0xFFFFFFEB, exception 0, data_resultRDY in the cycle after edge 33 (edge 17 with MULTDIV_RADIX4_EN); data_resultRDY high for exactly one cycle.
REQ-030 Multiply 0x00010000 x 0x00010000 -> data_result=0x00000000, exception 1.
REQ-031 Divide -100 / 7 -> data_result=0xFFFFFFF2 (-14), exception 0. Divide 5 / 0 -> result 0, exception 1. Divide 0x80000000 / 0xFFFFFFFF -> result 0x80000000, exception 1.
REQ-032 ctrl_MULT (6 x 6) at edge 0, then ctrl_DIV (100 / 10) at edge 10 -> single data_resultRDY in the cycle after edge 43 with data_result=10; no data_resultRDY near edge 33.
REQ-033 Reset asserted at edge 20 of a divide -> busy=0 and data_resultRDY never asserts; a new multiply 3 x 4 started afterwards returns 12.
REQ-034 ctrl_MULT and ctrl_DIV together with A=9, B=3 -> data_result=27 (multiply wins); operands toggled randomly after the start edge -> result unchanged.
